// File: rtl/hilo_div.sv
// hilo_div: multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}, which feeds HI (remainder) and LO (quotient).
// Operands are latched at start, so the EX stage may change its inputs freely
// while the divide is running.
module hilo_div #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [WIDTH:0]     rem, rem_n;       // partial remainder, one guard bit
   logic [WIDTH-1:0]   dvd, dvd_n;       // dividend, shifts into the quotient
   logic [WIDTH-1:0]   dsr, dsr_n;       // divisor magnitude
   logic               q_neg, q_neg_n;
   logic               r_neg, r_neg_n;
   logic [2*WIDTH-1:0] result_n;
   logic               ready_n;

   logic [WIDTH:0]     rem_sh, diff;
   logic [WIDTH-1:0]   mag1, mag2, quo_fix, rem_fix;
   logic               sign1, sign2;

   // Sign extraction and magnitude conversion of the incoming operands
   always_comb begin
      sign1 = signed_div_i & opdata1_i[WIDTH-1];
      sign2 = signed_div_i & opdata2_i[WIDTH-1];
      mag1  = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
      mag2  = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
   end

   // One restoring step plus the final sign fix-up of quotient and remainder
   always_comb begin
      rem_sh  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
      diff    = rem_sh - {1'b0, dsr};
      quo_fix = q_neg ? (~dvd + 1'b1) : dvd;
      rem_fix = r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
   end

   // Next-state and next-output logic
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rem_n    = rem;
      dvd_n    = dvd;
      dsr_n    = dsr;
      q_neg_n  = q_neg;
      r_neg_n  = r_neg;
      result_n = result_o;
      ready_n  = ready_o;
      case (state)
         S_IDLE: begin
            ready_n  = 1'b0;
            result_n = '0;
            // annul wins over a simultaneous start
            if (start_i && !annul_i) begin
               dvd_n   = mag1;
               dsr_n   = mag2;
               rem_n   = '0;
               cnt_n   = '0;
               q_neg_n = sign1 ^ sign2;
               r_neg_n = sign1;
               state_n = (opdata2_i == '0) ? S_DIVZERO : S_ON;
            end
         end
         S_DIVZERO: begin
            result_n = '0;
            if (annul_i) begin
               ready_n = 1'b0;
               state_n = S_IDLE;
            end else begin
               ready_n = 1'b1;
               state_n = S_END;
            end
         end
         S_ON: begin
            if (annul_i) begin
               ready_n  = 1'b0;
               result_n = '0;
               cnt_n    = '0;
               state_n  = S_IDLE;
            end else if (cnt == CW'(WIDTH)) begin
               result_n = {rem_fix, quo_fix};
               ready_n  = 1'b1;
               state_n  = S_END;
            end else begin
               // Non-negative trial difference (guard bit clear) sets the quotient bit
               if (!diff[WIDTH]) begin
                  rem_n = diff;
                  dvd_n = {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem_n = rem_sh;
                  dvd_n = {dvd[WIDTH-2:0], 1'b0};
               end
               cnt_n = cnt + CW'(1);
            end
         end
         S_END: begin
            // Result is held until EX drops start; annul has no effect here
            if (!start_i) begin
               ready_n  = 1'b0;
               result_n = '0;
               state_n  = S_IDLE;
            end
         end
         default: begin
            ready_n  = 1'b0;
            result_n = '0;
            state_n  = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         rem      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         rem      <= rem_n;
         dvd      <= dvd_n;
         dsr      <= dsr_n;
         q_neg    <= q_neg_n;
         r_neg    <= r_neg_n;
         result_o <= result_n;
         ready_o  <= ready_n;
      end
   end

endmodule

// File: tb/tb_hilo_div.sv
// Testbench for hilo_div: directed vector table, randomized operands against
// an arithmetic reference, and hand sequences for annul/reset/hold corners.
module tb_hilo_div;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [63:0] result;
   logic        ready;

   int tests = 0;
   int fails = 0;

   hilo_div #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div),
      .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
      .result_o(result), .ready_o(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer division; signed uses truncating 64-bit arithmetic
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 64'(sa / sb);
         r  = 64'(sa % sb);
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Issue one divide and count edges (including the sampling edge) to ready
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit scramble, input string nm);
      logic [63:0] exp;
      int          n, lat;
      exp = ref_div(sgn, a, b);
      lat = (b == 32'd0) ? 2 : 34;
      @(negedge clk);
      signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (scramble) begin
            op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
         end
      end while (!ready && n < 40);
      chk({nm, " latency"}, 64'(n), 64'(lat));
      chk({nm, " result"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         annul = (i == 1);
         if (scramble) begin
            op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
         end
         @(posedge clk); #1;
         chk({nm, " hold ready"}, 64'(ready), 64'd1);
         chk({nm, " hold result"}, result, exp);
      end
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      @(posedge clk); #1;
      chk({nm, " drop ready"}, 64'(ready), 64'd0);
      chk({nm, " drop result"}, result, 64'd0);
   endtask

   initial begin
      int  n;
      bit  seen;
      logic sg;
      logic [31:0] a, b;

      vecs[0]  = '{1'b0, 32'd100,       32'd7,         {32'h2,        32'hE}};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'h2,         {32'hFFFFFFFF, 32'hFFFFFFFD}};
      vecs[2]  = '{1'b1, 32'h7,         32'hFFFFFFFE,  {32'h1,        32'hFFFFFFFD}};
      vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0,        32'h80000000}};
      vecs[4]  = '{1'b1, 32'h1234,      32'h0,         64'h0};
      vecs[5]  = '{1'b0, 32'h1234,      32'h0,         64'h0};
      vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'h1,         {32'h0,        32'hFFFFFFFF}};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  {32'h0,        32'h1}};
      vecs[8]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  {32'hFFFFFFFF, 32'h3}};
      vecs[9]  = '{1'b0, 32'd5,         32'd9,         {32'h5,        32'h0}};
      vecs[10] = '{1'b1, 32'h80000000,  32'h1,         {32'h0,        32'h80000000}};

      // Reset state
      #12;
      chk("reset ready", 64'(ready), 64'd0);
      chk("reset result", result, 64'd0);
      @(negedge clk); rst = 1'b1;

      // Directed table: cross-check the reference itself, then the DUT
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("vec%0d ref", i), ref_div(vecs[i].sgn, vecs[i].a, vecs[i].b), vecs[i].exp);
         run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, 1'b0, $sformatf("vec%0d", i));
      end

      // Randomized operands
      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom);
         a  = $urandom;
         case (i % 6)
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = sg ? -$urandom_range(1, 15) : $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         run_div(sg, a, b, i % 3, 1'b0, $sformatf("rnd%0d", i));
      end

      // Annul mid-divide: no result may appear
      @(negedge clk);
      signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk); annul = 1'b1; start = 1'b0;
      @(negedge clk); annul = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1'b1;
      end
      chk("annul no ready", 64'(seen), 64'd0);
      run_div(1'b0, 32'd50, 32'd5, 0, 1'b0, "after annul");

      // Start with annul in IDLE: annul wins
      @(negedge clk); op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ready) seen = 1'b1;
      end
      chk("start+annul idle", 64'(seen), 64'd0);
      @(negedge clk); start = 1'b0; annul = 1'b0;

      // Annul in DIVZERO
      @(negedge clk); op1 = 32'd5; op2 = 32'd0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); annul = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("annul divzero ready", 64'(ready), 64'd0);
      @(negedge clk); annul = 1'b0;

      // Asynchronous reset mid-divide
      @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      repeat (15) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst mid ready", 64'(ready), 64'd0);
      chk("rst mid result", result, 64'd0);
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;

      // Asynchronous reset while a result is held: must clear before any edge
      @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!ready && n < 40);
      chk("pre-rst ready", 64'(ready), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("rst end ready", 64'(ready), 64'd0);
      chk("rst end result", result, 64'd0);
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      run_div(1'b0, 32'd9, 32'd3, 0, 1'b0, "after rst");

      // Operand stability while running and while held in END (annul ignored)
      run_div(1'b0, 32'd1000, 32'd7, 5, 1'b1, "stable u");
      run_div(1'b1, 32'hFFFFFC18, 32'd7, 5, 1'b1, "stable s");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

endmodule
